alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single RV32IMA ALU between `NREQ` requesters (e.g. execute stage, AMO sequencer, address-generation helper) with valid/ready handshakes. A round-robin arbiter grants one request at a time, registers its operation and operands into the ALU's inputs, captures the ALU's result and flags, and returns them on a shared response channel tagged with the requester index. The block drives the ALU's `alu_op`/`in1`/`in2` and consumes `out`/`zero`/`neg`/`overflow`/`carry`; the ALU itself is combinational.

## Interface
- `NREQ`, default 2: number of requesters, ≥2.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

Clock and reset are fixed: one clock; reset is asynchronous and active-high.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous abort of any in-flight operation.
- `req_valid` input `NREQ`: per-requester request valid.
- `req_ready` output `NREQ`: per-requester grant, at most one bit set.
- `req_op` input `NREQ`×`aluop_t`: per-requester operation.
- `req_in1`, `req_in2` input `NREQ`×32: per-requester operands (`word_t`).
- `resp_valid` output 1: result available.
- `resp_ready` input 1: consumer accepts the result.
- `resp_id` output `IDW`: index of the requester that owns the result.
- `resp_out` output 32: ALU result.
- `resp_flags` output 4: `{carry, overflow, neg, zero}`.
- `alu_op` output `aluop_t`: to the ALU.
- `alu_in1`, `alu_in2` output 32: to the ALU.
- `alu_out` input 32: from the ALU.
- `alu_zero`, `alu_neg`, `alu_overflow`, `alu_carry` input 1 each: from the ALU.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - If `flush`=0 and any `req_valid` is set, grant the first set index at or after `ptr`, searching cyclically.
  - `req_ready[g]`=1 combinationally for the granted index `g`.
  - On that edge: latch `req_op[g]`, `req_in1[g]` and `req_in2[g]` into the `alu_*` registers; set `id`=`g`, `ptr`=(`g`+1) mod `NREQ`; go to EXEC.
- **EXEC:** the ALU sees the registered inputs. On the next edge, capture `alu_out` and the four flags into the `resp_*` registers, set `resp_valid`=1, go to RESP.
- **RESP:** hold `resp_valid`, `resp_id`, `resp_out` and `resp_flags` stable until `resp_ready`=1, then clear `resp_valid` and go to IDLE.
- **No request acceptance outside IDLE:** `req_ready` is all-zero in EXEC and RESP.
- **`flush`=1 in any state:** next state IDLE and `resp_valid`=0 on the next edge. `ptr` is unchanged. No grant occurs in a cycle where `flush`=1. `flush` has priority over `resp_ready` and over capture in EXEC.
- **Registers hold:** `alu_*` registers keep their value outside the latch edge. `resp_*` data registers keep their value after the handshake; only `resp_valid` clears.
- **Combinational paths:** `req_ready` depends combinationally on `req_valid`, `ptr`, state and `flush`. Requesters must not make `req_valid` depend on `req_ready`.
- **Operand/flag handling:** widths pass through unmodified; no sign or zero extension and no flag interpretation occur in this block.

## Timing
- **Reset values (asynchronous):**
  - state = IDLE, `ptr`=0.
  - `req_ready`=0 while `rst` is asserted.
  - `resp_valid`=0, `resp_id`=0, `resp_out`=0, `resp_flags`=0.
  - `alu_op` = all-zero encoding, `alu_in1`=`alu_in2`=0.
- **Reset mid-operation:** drops the operation immediately. `resp_valid` falls asynchronously.
- **Latency:** an accept at edge E0 gives `resp_valid`=1 after edge E0+1.
- **Minimum spacing:** with `resp_ready` held at 1, the result handshake completes at E0+2, IDLE is re-entered and the next grant can occur at edge E0+3. Throughput is one operation per 3 cycles.
- **Simultaneous `req_valid`:** served strictly round-robin. The last-granted index has lowest priority on the next grant; the index wraps from `NREQ`-1 to 0.
- **Backpressure:** any number of cycles with `resp_ready`=0 stalls in RESP with outputs stable. No requester is granted during the stall.

## Test plan
- **Single request.** After reset, `req_valid[0]`=1 with ADD, `in1`=5, `in2`=7. Required:
  - `req_ready[0]` high for 1 cycle.
  - `resp_valid` 2 edges later with `resp_id`=0, `resp_out`=12, `resp_flags`=0000.
- **Contention and fairness.** `NREQ`=2, both requesters hold `req_valid` for 4 operations with `resp_ready`=1. Required:
  - grant order 0,1,0,1;
  - each response carries the matching id;
  - grants occur exactly 3 cycles apart.
- **Wrap-around.** `NREQ`=3, only requesters 2 and 0 valid, `ptr`=2 after a grant to 1. Required: grant order 2, 0, 2.
- **Backpressure.** SUB with `in1`=3, `in2`=3 (`resp_out`=0, zero=1), `resp_ready`=0 for 5 cycles. Required:
  - `resp_valid`, `resp_out` and `resp_flags` stable throughout;
  - `req_ready`=0 throughout;
  - IDLE and a new grant possible only after `resp_ready`=1.
- **Flush.** `flush`=1 in the EXEC cycle, then separately in RESP. Required:
  - no `resp_valid` after the EXEC flush;
  - in the RESP case, `resp_valid` falls on the next edge;
  - no grant in the flush cycle;
  - `ptr` preserved, so the next grant goes to the requester after the flushed one.
- **Reset mid-operation.** Assert `rst` asynchronously in RESP. Required:
  - `resp_valid` and all outputs go to reset values immediately;
  - after release, the first grant goes to index 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational RV32IMA ALU between
// NREQ requesters: grant, register operands into the ALU, capture result, respond.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ),
    parameter int OPW  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*OPW-1:0]  req_op_i,
    input  logic [NREQ*32-1:0]   req_in1_i,
    input  logic [NREQ*32-1:0]   req_in2_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [IDW-1:0]       resp_id_o,
    output logic [31:0]          resp_out_o,
    output logic [3:0]           resp_flags_o,
    output logic [OPW-1:0]       alu_op_o,
    output logic [31:0]          alu_in1_o,
    output logic [31:0]          alu_in2_o,
    input  logic [31:0]          alu_out_i,
    input  logic                 alu_zero_i,
    input  logic                 alu_neg_i,
    input  logic                 alu_overflow_i,
    input  logic                 alu_carry_i,
    output logic [1:0]           state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; req_ready is combinational, so req_valid must not depend on it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [31:0]     alu_in1_q, alu_in1_d;
    logic [31:0]     alu_in2_q, alu_in2_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [31:0]     resp_out_q, resp_out_d;
    logic [3:0]      resp_flags_q, resp_flags_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic            grant;

    // Cyclic search starting at ptr; the first valid index wins.
    always_comb begin : pick
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign grant = (state_q == S_IDLE) && !flush_i && grant_found && !rst;

    always_comb begin
        req_ready_o = '0;
        if (grant) req_ready_o[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        alu_op_d     = alu_op_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        resp_flags_d = resp_flags_q;
        if (flush_i) begin
            // Abort wins over capture and over the response handshake.
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        alu_op_d  = req_op_i[int'(grant_idx)*OPW +: OPW];
                        alu_in1_d = req_in1_i[int'(grant_idx)*32 +: 32];
                        alu_in2_d = req_in2_i[int'(grant_idx)*32 +: 32];
                        id_d      = grant_idx;
                        ptr_d     = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
                        state_d   = S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_out_d   = alu_out_i;
                    resp_flags_d = {alu_carry_i, alu_overflow_i, alu_neg_i, alu_zero_i};
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            alu_op_q     <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_out_q   <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            alu_op_q     <= alu_op_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_out_q   <= resp_out_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_out_o   = resp_out_q;
    assign resp_flags_o = resp_flags_q;
    assign alu_op_o     = alu_op_q;
    assign alu_in1_o    = alu_in1_q;
    assign alu_in2_o    = alu_in2_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester and a 3-requester instance, each
// wired to a reference ALU, with a scoreboard keyed on grants and responses.
module tb_alu_arbiter;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic resp_ready = 1'b1;
    logic sel = 1'b0;
    logic [2:0] d_valid = '0;
    logic [4:0] d_op [3];
    logic [31:0] d_a [3];
    logic [31:0] d_b [3];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    bit settled = 1'b0;
    logic [37:0] exp_q [$];
    int grant_log [$];
    int grant_cyc [$];

    always #5 clk = ~clk;

    function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] y;
        logic c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                y = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            default: y = a & b;
        endcase
        return {c, v, y[31], (y == 32'd0), y};
    endfunction

    // 2-requester instance
    logic [1:0] valid2, ready2;
    logic rv2; logic [0:0] id2; logic [31:0] out2; logic [3:0] fl2;
    logic [4:0] aop2; logic [31:0] ain1_2, ain2_2; logic [1:0] st2;
    logic [35:0] ar2;
    assign valid2 = sel ? 2'b00 : d_valid[1:0];
    assign ar2 = alu_model(aop2, ain1_2, ain2_2);

    alu_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .req_valid_i(valid2), .req_ready_o(ready2),
        .req_op_i({d_op[1], d_op[0]}), .req_in1_i({d_a[1], d_a[0]}), .req_in2_i({d_b[1], d_b[0]}),
        .resp_valid_o(rv2), .resp_ready_i(resp_ready), .resp_id_o(id2),
        .resp_out_o(out2), .resp_flags_o(fl2),
        .alu_op_o(aop2), .alu_in1_o(ain1_2), .alu_in2_o(ain2_2),
        .alu_out_i(ar2[31:0]), .alu_zero_i(ar2[32]), .alu_neg_i(ar2[33]),
        .alu_overflow_i(ar2[34]), .alu_carry_i(ar2[35]), .state_o(st2)
    );

    // 3-requester instance
    logic [2:0] valid3, ready3;
    logic rv3; logic [1:0] id3; logic [31:0] out3; logic [3:0] fl3;
    logic [4:0] aop3; logic [31:0] ain1_3, ain2_3; logic [1:0] st3;
    logic [35:0] ar3;
    assign valid3 = sel ? d_valid : 3'b000;
    assign ar3 = alu_model(aop3, ain1_3, ain2_3);

    alu_arbiter #(.NREQ(3)) dut3 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .req_valid_i(valid3), .req_ready_o(ready3),
        .req_op_i({d_op[2], d_op[1], d_op[0]}), .req_in1_i({d_a[2], d_a[1], d_a[0]}),
        .req_in2_i({d_b[2], d_b[1], d_b[0]}),
        .resp_valid_o(rv3), .resp_ready_i(resp_ready), .resp_id_o(id3),
        .resp_out_o(out3), .resp_flags_o(fl3),
        .alu_op_o(aop3), .alu_in1_o(ain1_3), .alu_in2_o(ain2_3),
        .alu_out_i(ar3[31:0]), .alu_zero_i(ar3[32]), .alu_neg_i(ar3[33]),
        .alu_overflow_i(ar3[34]), .alu_carry_i(ar3[35]), .state_o(st3)
    );

    logic [2:0] mon_ready;
    logic mon_rv; logic [1:0] mon_id; logic [31:0] mon_out; logic [3:0] mon_fl;
    assign mon_ready = sel ? ready3 : {1'b0, ready2};
    assign mon_rv    = sel ? rv3 : rv2;
    assign mon_id    = sel ? id3 : {1'b0, id2};
    assign mon_out   = sel ? out3 : out2;
    assign mon_fl    = sel ? fl3 : fl2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
        settled = 1'b1;
    endtask

    // Scoreboard: push on an observed grant, pop on a completed response.
    task automatic monitor();
        logic [1:0] gidx;
        logic [37:0] e;
        gidx = '0;
        if (mon_ready != 3'b000) begin
            chk("grant_onehot", 64'($countones(mon_ready)), 64'd1);
            for (int i = 0; i < 3; i++) if (mon_ready[i]) gidx = i[1:0];
            grant_log.push_back(int'(gidx));
            grant_cyc.push_back(cyc_n);
            exp_q.push_back({gidx, alu_model(d_op[gidx], d_a[gidx], d_b[gidx])});
        end
        if (mon_rv && resp_ready && !flush) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL resp_unexpected observed_out=%0h expected=no_response", mon_out);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("resp_item", {26'd0, mon_id, mon_fl, mon_out}, {26'd0, e});
            end
        end
    endtask

    task automatic step();
        if (!settled) #1;
        settled = 1'b0;
        monitor();
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        d_valid = '0;
        flush = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        grant_log.delete();
        grant_cyc.delete();
    endtask

    logic [35:0] r_bp;

    initial begin
        for (int i = 0; i < 3; i++) begin
            d_op[i] = OP_ADD; d_a[i] = '0; d_b[i] = '0;
        end
        // Reset values, with requests pending to prove no grant under reset
        d_valid = 3'b111;
        #2;
        chk("rst_ready2", 64'(ready2), 64'd0);
        chk("rst_ready3", 64'(ready3), 64'd0);
        chk("rst_resp_valid", 64'(rv2), 64'd0);
        chk("rst_resp_id", 64'(id2), 64'd0);
        chk("rst_resp_out", 64'(out2), 64'd0);
        chk("rst_resp_flags", 64'(fl2), 64'd0);
        chk("rst_alu_op", 64'(aop2), 64'd0);
        chk("rst_alu_in", {ain1_2, ain2_2}, 64'd0);
        chk("rst_state", 64'(st2), 64'd0);
        do_reset();

        // Single request: ADD 5 + 7 from requester 0
        d_op[0] = OP_ADD; d_a[0] = 32'd5; d_b[0] = 32'd7; d_valid = 3'b001;
        settle();
        chk("single_grant", 64'(ready2), 64'd1);
        step();
        settle();
        chk("single_ready_once", 64'(ready2), 64'd0);
        chk("single_exec_no_valid", 64'(rv2), 64'd0);
        step();
        d_valid = '0;
        settle();
        chk("single_resp_valid", 64'(rv2), 64'd1);
        chk("single_resp", {26'd0, id2, fl2, out2}, {26'd0, 1'b0, 4'b0000, 32'd12});
        step();
        step();

        // Contention, 2 requesters
        do_reset();
        d_op[0] = OP_ADD; d_a[0] = 32'd10;  d_b[0] = 32'd20;
        d_op[1] = OP_SUB; d_a[1] = 32'd100; d_b[1] = 32'd1;
        d_valid = 3'b011;
        for (int i = 0; i < 10; i++) step();
        d_valid = '0;
        for (int i = 0; i < 3; i++) step();
        chk("cont_grants", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("cont_order", 64'(grant_log[i]), 64'(i % 2));
        for (int i = 1; i < grant_cyc.size(); i++)
            chk("cont_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd3);
        chk("cont_drained", 64'(exp_q.size()), 64'd0);

        // Wrap-around, 3 requesters: grant 1 first, then 2 and 0 contend
        do_reset();
        sel = 1'b1;
        d_op[2] = OP_SUB; d_a[2] = 32'd1; d_b[2] = 32'd2;
        d_valid = 3'b010;
        step();
        d_valid = '0;
        step(); step();
        d_valid = 3'b101;
        for (int i = 0; i < 7; i++) step();
        d_valid = '0;
        for (int i = 0; i < 3; i++) step();
        chk("wrap_grants", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            chk("wrap_g0", 64'(grant_log[0]), 64'd1);
            chk("wrap_g1", 64'(grant_log[1]), 64'd2);
            chk("wrap_g2", 64'(grant_log[2]), 64'd0);
            chk("wrap_g3", 64'(grant_log[3]), 64'd2);
        end
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);
        sel = 1'b0;

        // Backpressure: SUB 3 - 3 held for 5 cycles with requester 1 waiting
        d_op[0] = OP_SUB; d_a[0] = 32'd3; d_b[0] = 32'd3;
        d_op[1] = OP_ADD; d_a[1] = 32'd1; d_b[1] = 32'd1;
        r_bp = alu_model(OP_SUB, 32'd3, 32'd3);
        resp_ready = 1'b0;
        d_valid = 3'b001;
        settle();
        chk("bp_grant", 64'(ready2), 64'd1);
        step();
        d_valid = 3'b010;
        settle();
        chk("bp_exec_ready", 64'(ready2), 64'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_valid", 64'(rv2), 64'd1);
            chk("bp_out", 64'(out2), 64'(r_bp[31:0]));
            chk("bp_flags", 64'(fl2), 64'(r_bp[35:32]));
            chk("bp_ready", 64'(ready2), 64'd0);
            step();
        end
        resp_ready = 1'b1;
        settle();
        chk("bp_release_ready", 64'(ready2), 64'd0);
        step();
        settle();
        chk("bp_next_grant", 64'(ready2), 64'd2);
        step();
        d_valid = '0;
        step(); step();

        // Flush in EXEC
        d_op[0] = OP_ADD; d_a[0] = 32'd7; d_b[0] = 32'd8;
        d_valid = 3'b001;
        step();
        d_valid = '0;
        flush = 1'b1;
        settle();
        chk("fx_ready", 64'(ready2), 64'd0);
        step();
        flush = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        settle();
        chk("fx_no_valid", 64'(rv2), 64'd0);
        chk("fx_state_idle", 64'(st2), 64'd0);
        step();
        settle();
        chk("fx_no_valid_later", 64'(rv2), 64'd0);
        d_valid = 3'b011;
        flush = 1'b1;
        settle();
        chk("flush_cycle_no_grant", 64'(ready2), 64'd0);
        step();
        flush = 1'b0;
        settle();
        chk("fx_ptr_kept", 64'(ready2), 64'd2);
        step();
        d_valid = '0;
        settle();
        chk("fr_exec_valid", 64'(rv2), 64'd0);
        step();
        settle();
        chk("fr_resp_valid", 64'(rv2), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        d_valid = 3'b011;
        settle();
        chk("fr_valid_fell", 64'(rv2), 64'd0);
        chk("fr_ptr_kept", 64'(ready2), 64'd1);
        step();

        // Reset in RESP
        d_valid = '0;
        resp_ready = 1'b0;
        step(); step();
        settle();
        chk("rm_resp_valid", 64'(rv2), 64'd1);
        chk("rm_resp_out", 64'(out2), 64'd15);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_valid_async", 64'(rv2), 64'd0);
        chk("rm_out_async", {26'd0, id2, fl2, out2}, 64'd0);
        chk("rm_alu_async", {27'd0, aop2, ain1_2}, 64'd0);
        chk("rm_in2_async", 64'(ain2_2), 64'd0);
        chk("rm_state_async", 64'(st2), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;
        d_valid = 3'b011;
        settle();
        chk("rm_first_grant", 64'(ready2), 64'd1);
        step();
        d_valid = '0;
        for (int i = 0; i < 3; i++) step();
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
